// File: rtl/uart_apb_tx_arbiter.sv
// Two-requester round-robin byte arbiter that configures a UART over APB, then polls TXRDY and writes each byte.
// Optional macro UART_TX_ARB_FRAC_BAUD_EN adds the fractional-baud register write to the init sequence.
module uart_apb_tx_arbiter #(
   parameter logic [12:0] BAUD_VAL   = 13'd1,
   parameter logic [2:0]  BAUD_FRAC  = 3'd0,
   parameter logic        BIT8       = 1'b1,
   parameter logic        PARITY_EN  = 1'b0,
   parameter logic        ODD_N_EVEN = 1'b0
) (
   input  logic       PCLK,
   input  logic       PRESET,
   output logic [4:0] M_PADDR,
   output logic       M_PSEL,
   output logic       M_PENABLE,
   output logic       M_PWRITE,
   output logic [7:0] M_PWDATA,
   input  logic [7:0] M_PRDATA,
   input  logic       M_PREADY,
   input  logic       REQ0_VALID,
   input  logic       REQ1_VALID,
   input  logic [7:0] REQ0_DATA,
   input  logic [7:0] REQ1_DATA,
   output logic       REQ0_READY,
   output logic       REQ1_READY,
   output logic       INIT_DONE,
   output logic       GRANT,
   output logic       BUSY
);

   localparam logic [4:0] ADDR_TX   = 5'h00;
   localparam logic [4:0] ADDR_CR1  = 5'h08;
   localparam logic [4:0] ADDR_CR2  = 5'h0C;
   localparam logic [4:0] ADDR_STAT = 5'h10;
   localparam logic [4:0] ADDR_CR3  = 5'h14;

   typedef enum logic [2:0] {INIT_CR1, INIT_CR2, INIT_CR3, IDLE, POLL, WRITE} state_t;

   // {address, data} of the configuration write owned by each init state
   function automatic logic [12:0] f_init_xfer(input state_t s);
      case (s)
         INIT_CR1: f_init_xfer = {ADDR_CR1, BAUD_VAL[7:0]};
         INIT_CR2: f_init_xfer = {ADDR_CR2, BAUD_VAL[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
         default:  f_init_xfer = {ADDR_CR3, 5'b0, BAUD_FRAC};
      endcase
   endfunction

   state_t     r_state;
   logic       r_psel, r_penable, r_pwrite;
   logic [4:0] r_paddr;
   logic [7:0] r_pwdata;
   logic       r_ready0, r_ready1, r_init_done, r_grant;
   logic [7:0] r_data;

   logic w_done, w_any_valid, w_win, w_ready_any;
   logic w_unused_prdata;

   assign w_done          = r_psel & r_penable & M_PREADY;
   assign w_any_valid     = REQ0_VALID | REQ1_VALID;
   assign w_win           = (REQ0_VALID & REQ1_VALID) ? ~r_grant : REQ1_VALID;
   assign w_ready_any     = r_ready0 | r_ready1;
   assign w_unused_prdata = ^M_PRDATA[7:1];

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= INIT_CR1;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= 5'h00;
         r_pwdata    <= 8'h00;
         r_ready0    <= 1'b0;
         r_ready1    <= 1'b0;
         r_init_done <= 1'b0;
         r_grant     <= 1'b1;
      end else begin
         r_ready0 <= 1'b0;
         r_ready1 <= 1'b0;
         if (r_psel && !r_penable)
            r_penable <= 1'b1;
         case (r_state)
            INIT_CR1, INIT_CR2, INIT_CR3: begin
               if (!r_psel) begin
                  r_psel                <= 1'b1;
                  r_penable             <= 1'b0;
                  r_pwrite              <= 1'b1;
                  {r_paddr, r_pwdata}   <= f_init_xfer(r_state);
               end else if (w_done) begin
                  // Init writes run back to back: the next SETUP follows the completing ACCESS
                  if (r_state == INIT_CR1) begin
                     r_state             <= INIT_CR2;
                     r_penable           <= 1'b0;
                     {r_paddr, r_pwdata} <= f_init_xfer(INIT_CR2);
                  end
`ifdef UART_TX_ARB_FRAC_BAUD_EN
                  else if (r_state == INIT_CR2) begin
                     r_state             <= INIT_CR3;
                     r_penable           <= 1'b0;
                     {r_paddr, r_pwdata} <= f_init_xfer(INIT_CR3);
                  end
`endif
                  else begin
                     r_state     <= IDLE;
                     r_psel      <= 1'b0;
                     r_penable   <= 1'b0;
                     r_pwrite    <= 1'b0;
                     r_init_done <= 1'b1;
                  end
               end
            end
            IDLE: begin
               // Skip the READY cycle so the just-served requester can retire its byte first
               if (w_any_valid && !w_ready_any) begin
                  r_state   <= POLL;
                  r_grant   <= w_win;
                  r_data    <= w_win ? REQ1_DATA : REQ0_DATA;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_pwrite  <= 1'b0;
                  r_paddr   <= ADDR_STAT;
                  r_pwdata  <= 8'h00;
               end
            end
            POLL: begin
               if (w_done) begin
                  r_penable <= 1'b0;
                  if (M_PRDATA[0]) begin
                     r_state  <= WRITE;
                     r_pwrite <= 1'b1;
                     r_paddr  <= ADDR_TX;
                     r_pwdata <= r_data;
                  end
               end
            end
            WRITE: begin
               if (w_done) begin
                  r_state   <= IDLE;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_pwrite  <= 1'b0;
                  r_ready0  <= ~r_grant;
                  r_ready1  <= r_grant;
               end
            end
            default: begin
               r_state   <= INIT_CR1;
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
            end
         endcase
      end
   end

   assign M_PSEL     = r_psel;
   assign M_PENABLE  = r_penable;
   assign M_PWRITE   = r_pwrite;
   assign M_PADDR    = r_paddr;
   assign M_PWDATA   = r_pwdata;
   assign REQ0_READY = r_ready0;
   assign REQ1_READY = r_ready1;
   assign INIT_DONE  = r_init_done;
   assign GRANT      = r_grant;
   assign BUSY       = (r_state != IDLE);

endmodule
